// File: rtl/oam_dma.sv
// Sprite OAM DMA engine: a CPU write to TRIG_ADDR halts the CPU and copies one
// 256-byte page to the OAM data port as alternating read/write bus cycles.
module oam_dma #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    REG_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] TRIG_ADDR  = 16'h4014,
    parameter logic [ADDR_WIDTH-1:0] OAM_ADDR   = 16'h2004
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [REG_WIDTH-1:0]  cpu_dout,
    input  logic                  cpu_we,
    input  logic [REG_WIDTH-1:0]  mem_din,
    output logic                  cpu_rdy,
    output logic                  dma_active,
    output logic [ADDR_WIDTH-1:0] dma_addr,
    output logic                  dma_we,
    output logic [REG_WIDTH-1:0]  dma_dout,
    output logic                  dma_done
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t                 state;
    logic                   parity;
    logic [REG_WIDTH-1:0]   page;
    logic [7:0]             idx;
    logic [REG_WIDTH-1:0]   data_reg;
    logic                   trigger;

    function automatic logic [ADDR_WIDTH-1:0] page_addr(input logic [REG_WIDTH-1:0] p,
                                                        input logic [7:0]           i);
        return ADDR_WIDTH'({p, i});
    endfunction

    assign trigger  = cpu_we && (cpu_addr == TRIG_ADDR);

    // The write data is the captured byte, presented only while the strobe is up.
    assign dma_dout = dma_we ? data_reg : '0;

    // NOTE: all state and output registers use non-blocking assignments so every
    // branch below sees the values from the start of the cycle, not partial updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            parity     <= 1'b0;
            page       <= '0;
            idx        <= '0;
            data_reg   <= '0;
            cpu_rdy    <= 1'b1;
            dma_active <= 1'b0;
            dma_addr   <= '0;
            dma_we     <= 1'b0;
            dma_done   <= 1'b0;
        end else begin
            parity   <= ~parity;
            dma_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (trigger) begin
                        page       <= cpu_dout;
                        idx        <= '0;
                        state      <= HALT;
                        cpu_rdy    <= 1'b0;
                        dma_active <= 1'b1;
                        // Dummy cycles park the bus on the first source byte of the page.
                        dma_addr   <= page_addr(cpu_dout, 8'h00);
                    end
                end

                HALT: begin
                    state <= parity ? ALIGN : READ;
                end

                ALIGN: begin
                    state <= READ;
                end

                READ: begin
                    data_reg <= mem_din;
                    state    <= WRITE;
                    dma_addr <= OAM_ADDR;
                    dma_we   <= 1'b1;
                end

                WRITE: begin
                    dma_we <= 1'b0;
                    if (idx == 8'hFF) begin
                        state      <= IDLE;
                        dma_done   <= 1'b1;
                        cpu_rdy    <= 1'b1;
                        dma_active <= 1'b0;
                        dma_addr   <= '0;
                    end else begin
                        idx      <= idx + 8'd1;
                        state    <= READ;
                        dma_addr <= page_addr(page, idx + 8'd1);
                    end
                end

                default: begin
                    state      <= IDLE;
                    cpu_rdy    <= 1'b1;
                    dma_active <= 1'b0;
                    dma_addr   <= '0;
                    dma_we     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: an offset-based transfer model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_we;
    logic [7:0]  mem_din;
    logic        cpu_rdy;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic        dma_we;
    logic [7:0]  dma_dout;
    logic        dma_done;

    logic [7:0]  mem [0:65535];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    oam_dma dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_we     (cpu_we),
        .mem_din    (mem_din),
        .cpu_rdy    (cpu_rdy),
        .dma_active (dma_active),
        .dma_addr   (dma_addr),
        .dma_we     (dma_we),
        .dma_dout   (dma_dout),
        .dma_done   (dma_done)
    );

    always #5 clk = ~clk;

    assign mem_din = mem[dma_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Transfer model: a transfer is an offset counter from its first halted cycle.
    // Offsets below 1+align are dummies, then 512 alternating read/write cycles,
    // then an idle cycle carrying the done pulse.
    bit         m_valid = 1'b0;
    bit         m_busy, m_par, m_done, m_align;
    int         m_off;
    logic [7:0] m_page;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_par   = 1'b0;
            m_done  = 1'b0;
        end else if (m_valid) begin
            m_par  = ~m_par;
            m_done = 1'b0;
            if (m_busy) begin
                m_off++;
                if (m_off == 513 + int'(m_align)) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (cpu_we && cpu_addr == 16'h4014) begin
                m_busy  = 1'b1;
                m_off   = 0;
                m_page  = cpu_dout;
                m_align = m_par;
            end
        end
    end

    // Observations gathered alongside the per-cycle compare.
    logic [7:0]  wq[$];
    logic [15:0] rdq[$];
    logic [15:0] prev_addr = '0;
    int          run = 0, last_run = 0, done_cnt = 0, zero_hit = 0;

    logic        e_rdy, e_act, e_we, e_done;
    logic [15:0] e_addr;
    logic [7:0]  e_dout;

    always @(negedge clk) begin
        if (m_valid) begin
            cyc++;
            e_rdy = 1'b1; e_act = 1'b0; e_addr = '0; e_we = 1'b0; e_dout = '0; e_done = m_done;
            if (m_busy) begin
                int         k;
                logic [7:0] ii;
                e_rdy  = 1'b0;
                e_act  = 1'b1;
                e_done = 1'b0;
                k      = m_off - 1 - int'(m_align);
                if (k < 0) begin
                    e_addr = {m_page, 8'h00};
                end else begin
                    ii = 8'(k / 2);
                    if (k % 2 == 0) begin
                        e_addr = {m_page, ii};
                    end else begin
                        e_addr = 16'h2004;
                        e_we   = 1'b1;
                        e_dout = mem[{m_page, ii}];
                    end
                end
            end
            check("cpu_rdy",    32'(cpu_rdy),    32'(e_rdy));
            check("dma_active", 32'(dma_active), 32'(e_act));
            check("dma_addr",   32'(dma_addr),   32'(e_addr));
            check("dma_we",     32'(dma_we),     32'(e_we));
            check("dma_dout",   32'(dma_dout),   32'(e_dout));
            check("dma_done",   32'(dma_done),   32'(e_done));

            if (cpu_rdy === 1'b0) run++;
            else if (run != 0) begin
                last_run = run;
                run      = 0;
            end
            if (dma_we === 1'b1) begin
                wq.push_back(dma_dout);
                rdq.push_back(prev_addr);
            end
            if (dma_done === 1'b1) done_cnt++;
            if (dma_active === 1'b1 && dma_addr == 16'h0000) zero_hit++;
            prev_addr = dma_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_bus(input logic we, input logic [15:0] a, input logic [7:0] d);
        cpu_we   = we;
        cpu_addr = a;
        cpu_dout = d;
    endtask

    // Issue a trigger so that the halted cycle sees parity want_par.
    task automatic trigger(input logic [7:0] p, input bit want_par);
        tick();
        if (m_par == want_par) tick();
        wq.delete();
        rdq.delete();
        set_bus(1'b1, 16'h4014, p);
        tick();
        set_bus(1'b0, 16'h0000, 8'h00);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (cpu_rdy !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) check({name, "_timeout"}, 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_done, n;

        for (int a = 0; a < 65536; a++)
            mem[a] = (a[15:8] == 8'hFF) ? (a[7:0] ^ 8'h3C) : (a[7:0] ^ 8'hA5);

        reset = 1'b1;
        set_bus(1'b0, 16'h0000, 8'h00);
        repeat (5) tick();
        check("rst_rdy",    32'(cpu_rdy),    32'd1);
        check("rst_active", 32'(dma_active), 32'd0);
        reset = 1'b0;

        // Even transfer: parity 0 in the halted cycle.
        trigger(8'h02, 1'b0);
        wait_ready("even");
        check("even_run",    32'(last_run),  32'd513);
        check("even_writes", 32'(wq.size()), 32'd256);
        check("even_d0",     32'(wq[0]),     32'hA5);
        check("even_d1",     32'(wq[1]),     32'hA4);
        check("even_d255",   32'(wq[255]),   32'h5A);
        check("even_rd0",    32'(rdq[0]),    32'h0200);
        check("even_rd255",  32'(rdq[255]),  32'h02FF);
        check("even_done",   32'(done_cnt),  32'd1);

        // Odd transfer: parity 1 in the halted cycle adds the align cycle.
        trigger(8'h02, 1'b1);
        wait_ready("odd");
        check("odd_run",    32'(last_run),  32'd514);
        check("odd_writes", 32'(wq.size()), 32'd256);
        check("odd_d0",     32'(wq[0]),     32'hA5);
        check("odd_d255",   32'(wq[255]),   32'h5A);
        check("odd_done",   32'(done_cnt),  32'd2);

        // Non-trigger accesses.
        wq.delete();
        set_bus(1'b1, 16'h4015, 8'h02); tick();
        set_bus(1'b0, 16'h4014, 8'h02); tick();
        set_bus(1'b1, 16'h2004, 8'h02); tick();
        set_bus(1'b0, 16'h0000, 8'h00);
        repeat (3) tick();
        check("nt_rdy",    32'(cpu_rdy),   32'd1);
        check("nt_run",    32'(run),       32'd0);
        check("nt_writes", 32'(wq.size()), 32'd0);
        check("nt_done",   32'(done_cnt),  32'd2);

        // Abort with reset during the write of idx 100.
        base_done = done_cnt;
        trigger(8'h02, 1'b0);
        n = 0;
        while (!(m_busy && m_off == 202 + int'(m_align)) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) check("abort_timeout", 32'd0, 32'd1);
        check("abort_we", 32'(dma_we), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_rdy", 32'(cpu_rdy), 32'd1);
        repeat (5) tick();
        check("abort_writes", 32'(wq.size()), 32'd101);
        check("abort_done",   32'(done_cnt),  32'(base_done));

        trigger(8'h03, 1'b0);
        wait_ready("restart");
        check("restart_rd0", 32'(rdq[0]),    32'h0300);
        check("restart_d0",  32'(wq[0]),     32'hA5);
        check("restart_cnt", 32'(wq.size()), 32'd256);

        // Page FF with an ignored mid-transfer trigger, then a trigger in the done cycle.
        trigger(8'hFF, 1'b1);
        repeat (50) tick();
        set_bus(1'b1, 16'h4014, 8'h07);
        tick();
        set_bus(1'b0, 16'h0000, 8'h00);
        n = 0;
        while (!m_done && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) check("ff_timeout", 32'd0, 32'd1);
        check("ff_done_now", 32'(dma_done),  32'd1);
        check("ff_writes",   32'(wq.size()), 32'd256);
        check("ff_rd255",    32'(rdq[255]),  32'hFFFF);
        check("ff_d255",     32'(wq[255]),   32'hC3);
        check("ff_zero",     32'(zero_hit),  32'd0);

        wq.delete();
        rdq.delete();
        set_bus(1'b1, 16'h4014, 8'h01);
        tick();
        set_bus(1'b0, 16'h0000, 8'h00);
        check("b2b_rdy", 32'(cpu_rdy), 32'd0);
        wait_ready("b2b");
        check("b2b_rd0",    32'(rdq[0]),    32'h0100);
        check("b2b_d0",     32'(wq[0]),     32'hA5);
        check("b2b_writes", 32'(wq.size()), 32'd256);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADDR_WIDTH, 16, bus address width.
- REG_WIDTH, 8, data width.
- TRIG_ADDR, 16'h4014, CPU write address that starts a transfer.
- OAM_ADDR, 16'h2004, destination data port address.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; reset is synchronous and active-high.
- reset, in, 1, synchronous active-high reset.
- cpu_addr, in, ADDR_WIDTH, CPU address bus.
- cpu_dout, in, REG_WIDTH, CPU write data.
- cpu_we, in, 1, CPU write strobe (high = write this cycle).
- mem_din, in, REG_WIDTH, memory read data; valid in the same cycle as dma_addr.
- cpu_rdy, out, 1, CPU ready; low halts the CPU.
- dma_active, out, 1, high = DMA owns the bus (bus mux select).
- dma_addr, out, ADDR_WIDTH, DMA bus address.
- dma_we, out, 1, DMA write strobe.
- dma_dout, out, REG_WIDTH, DMA write data.
- dma_done, out, 1, one-cycle pulse when a transfer completes.

Function
REQ-003 All outputs SHALL be decoded from registered state only (Moore); no combinational path from inputs to outputs.
REQ-004 A free-running parity bit SHALL toggle every cycle; it resets to 0.
REQ-005 States SHALL be IDLE, HALT, ALIGN, READ, WRITE.
REQ-006 IDLE: when cpu_we=1 and cpu_addr==TRIG_ADDR, the block SHALL latch page=cpu_dout, clear idx to 0 and go to HALT.
REQ-007 In all other IDLE cycles the block SHALL stay in IDLE.
REQ-008 HALT SHALL last one cycle and is a dummy (no bus access).
- Next state is ALIGN if parity=1 during HALT, else READ.
REQ-009 ALIGN SHALL last one cycle, is a dummy, and goes to READ.
REQ-010 READ SHALL drive dma_addr={page,idx} with dma_we=0, capture mem_din into data_reg at the ending edge, and go to WRITE.
REQ-011 WRITE SHALL drive dma_addr=OAM_ADDR, dma_we=1 and dma_dout=data_reg.
- If idx==8'hFF: next state IDLE, dma_done=1 in the following cycle.
- Otherwise: idx increments by 1 and the next state is READ.
REQ-012 idx SHALL be 8 bits and addresses SHALL never cross the page; page FF covers FF00..FFFF only.
REQ-013 cpu_rdy SHALL be 0 and dma_active 1 in every state except IDLE.
REQ-014 Halt length SHALL be 513 cycles (parity 0 in HALT) or 514 cycles (parity 1 in HALT), counted from the cycle after the trigger to the cycle before cpu_rdy returns high.
REQ-015 Exactly 256 reads and 256 writes SHALL occur per transfer, alternating, in ascending idx order.
REQ-016 Trigger writes seen while not in IDLE SHALL be ignored, with page unchanged.
REQ-017 A trigger in the same cycle that dma_done is asserted SHALL be accepted.
REQ-018 Writes to any other address, and cycles at TRIG_ADDR with cpu_we=0, SHALL have no effect.
REQ-019 In IDLE the block SHALL drive dma_addr=0, dma_we=0 and dma_dout=0.

Reset
REQ-020 On reset=1 at a clock edge, the block SHALL:
- go to IDLE, with cpu_rdy=1, dma_active=0, dma_we=0, dma_done=0;
- set dma_addr=0, dma_dout=0, page=0, idx=0, data_reg=0, parity=0.
REQ-021 Reset SHALL take priority over a trigger in the same cycle.
REQ-022 Reset mid-transfer SHALL abort the transfer with no further writes; no dma_done pulse is produced.

Verification
REQ-023 Reset check: hold reset 5 cycles -> cpu_rdy=1, dma_active=0, dma_we=0, dma_addr=0 every cycle.
REQ-024 Even transfer: preload 0200..02FF with idx^8'hA5; write 8'h02 to 4014 with parity 0 in HALT.
- Response: 256 writes to 2004 with data A5,A4,...,5A in order.
- cpu_rdy low for 513 cycles, one dma_done pulse.
REQ-025 Odd transfer: same stimulus with parity 1 in HALT -> same data, cpu_rdy low for 514 cycles.
REQ-026 Non-trigger: write to 4015, cpu_we=0 at 4014, write to 2004 -> no state change, cpu_rdy stays 1.
REQ-027 Abort: assert reset at the WRITE of idx 100 -> cpu_rdy=1 the next cycle, no further dma_we.
- A new trigger with 8'h03 then restarts at 0300.
REQ-028 Page wrap and back-to-back:
- Page FF -> last read at FFFF, no access to 0000.
- A second trigger in the dma_done cycle starts a new transfer immediately.
- A trigger during a transfer is ignored.
